// File: rtl/riscv_mc_pkg.sv
// Shared types and constants for the multicycle RV32 subset core:
// controller states, opcode/funct3 values and the 3-bit ALU control code.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // sub_sel must be 0 for I-type: instr[30] there is an immediate bit.
    function automatic logic [2:0] alu_ctrl(input logic [2:0] funct3, input logic sub_sel);
        logic [2:0] ctrl;
        ctrl = ALU_ADD;
        case (funct3)
            F3_ADD:  ctrl = sub_sel ? ALU_SUB : ALU_ADD;
            F3_SLT:  ctrl = ALU_SLT;
            F3_OR:   ctrl = ALU_OR;
            F3_AND:  ctrl = ALU_AND;
            default: ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/riscv_mc_core_ctrl.sv
// Main controller FSM for the multicycle core: sequences fetch, decode,
// execute and memory phases and owns the memory request/write strobes.
module mc_ctrl
    import riscv_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       xfer,
    output state_t     state,
    output logic       mem_req,
    output logic       mem_we,
    output logic       illegal
);

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (xfer) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (xfer) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (xfer) state_d = S_FETCH;
            S_EXECUTER, S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB, S_BEQ, S_JAL:  state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    assign illegal_d = illegal_q | (state_d == S_TRAP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Request is decoded from the state flop but masked by reset so a held
    // reset never presents a fetch, and the first post-reset cycle does.
    assign mem_req = ~reset & ((state_q == S_FETCH) || (state_q == S_MEMREAD)
                               || (state_q == S_MEMWRITE));
    assign mem_we  = ~reset & (state_q == S_MEMWRITE);
    assign state   = state_q;
    assign illegal = illegal_q;

endmodule

// File: rtl/riscv_mc_core.sv
// Multicycle RV32 subset core with a single unified memory port.
// Datapath registers, register file, immediate extension and ALU live here.
module riscv_mc_core
    import riscv_mc_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            illegal,
    output logic [XLEN-1:0] pc
);

    state_t          state;
    logic            xfer;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic [XLEN-1:0] oldpc_q, oldpc_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] aluout_q, aluout_d;
    logic [XLEN-1:0] data_q, data_d;

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;

    logic [XLEN-1:0] rf_q [32];
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            rf_we;
    logic [XLEN-1:0] rf_wd;

    logic [2:0]      alu_op;
    logic [XLEN-1:0] alu_a, alu_b, alu_y;

    assign xfer = mem_req & mem_ready;

    mc_ctrl u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .opcode  (opcode),
        .xfer    (xfer),
        .state   (state),
        .mem_req (mem_req),
        .mem_we  (mem_we),
        .illegal (illegal)
    );

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];

    assign imm_i = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];

    always_ff @(posedge clk) begin
        if (rf_we && (rd != 5'd0)) begin
            rf_q[rd] <= rf_wd;
        end
    end

    assign alu_a  = a_q;
    assign alu_b  = (state == S_EXECUTER) ? b_q : imm_i;
    assign alu_op = alu_ctrl(funct3, (state == S_EXECUTER) & ir_q[30]);

    always_comb begin
        alu_y = '0;
        case (alu_op)
            ALU_ADD: alu_y = alu_a + alu_b;
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y[0] = $signed(alu_a) < $signed(alu_b);
            default: alu_y = alu_a + alu_b;
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        oldpc_d  = oldpc_q;
        a_d      = a_q;
        b_d      = b_q;
        aluout_d = aluout_q;
        data_d   = data_q;
        rf_we    = 1'b0;
        rf_wd    = aluout_q;
        case (state)
            S_FETCH: begin
                if (xfer) begin
                    ir_d    = mem_rdata;
                    oldpc_d = pc_q;
                    pc_d    = pc_q + XLEN'(4);
                end
            end
            S_DECODE: begin
                a_d = rs1_val;
                b_d = rs2_val;
            end
            S_MEMADR:   aluout_d = a_q + ((opcode == OP_STORE) ? imm_s : imm_i);
            S_MEMREAD:  if (xfer) data_d = mem_rdata;
            S_MEMWB: begin
                rf_we = 1'b1;
                rf_wd = data_q;
            end
            S_EXECUTER, S_EXECUTEI: aluout_d = alu_y;
            S_ALUWB: begin
                rf_we = 1'b1;
                rf_wd = aluout_q;
            end
            S_BEQ:      if (a_q == b_q) pc_d = oldpc_q + imm_b;
            S_JAL: begin
                rf_we = 1'b1;
                rf_wd = oldpc_q + XLEN'(4);
                pc_d  = oldpc_q + imm_j;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            oldpc_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            data_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            oldpc_q  <= oldpc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            data_q   <= data_d;
        end
    end

    assign mem_addr  = (state == S_FETCH) ? pc_q : aluout_q;
    assign mem_wdata = b_q;
    assign pc        = pc_q;

endmodule

// File: tb/tb_riscv_mc_core.sv
// Directed bench for riscv_mc_core: small programs in a wait-state memory
// model, with transfer log and hand-computed expected results.
module tb_riscv_mc_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, illegal;
    logic [31:0] mem_addr, mem_wdata, pc;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    always #5 clk = ~clk;

    riscv_mc_core #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .illegal   (illegal),
        .pc        (pc)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    logic [31:0] mem [256];
    logic [31:0] tr_addr [$];
    logic [31:0] tr_wdata [$];
    logic        tr_we [$];
    int          tr_cyc [$];

    int          cyc = 0;
    int          wcnt = 0;
    int          wait_n = 0;
    int          unstable = 0;
    int          hold_cnt = 0;
    logic [31:0] wait_addr = '1;
    logic [31:0] hold_addr = '1;
    logic        pend = 1'b0;
    logic [31:0] p_addr = '0, p_wd = '0;
    logic        p_we = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory responder: decides ready just after negedge, logs completed transfers.
    always @(negedge clk) begin
        #1;
        cyc++;
        if (mem_req) begin
            if (pend && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wd))
                unstable++;
            if (mem_addr == hold_addr) hold_cnt++;
            if (wcnt >= ((mem_addr == wait_addr) ? wait_n : 0)) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[9:2]];
                tr_addr.push_back(mem_addr);
                tr_we.push_back(mem_we);
                tr_wdata.push_back(mem_wdata);
                tr_cyc.push_back(cyc);
                if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
                wcnt = 0;
                pend = 1'b0;
            end else begin
                mem_ready = 1'b0;
                wcnt++;
                pend   = 1'b1;
                p_addr = mem_addr;
                p_we   = mem_we;
                p_wd   = mem_wdata;
            end
        end else begin
            mem_ready = 1'b0;
            wcnt = 0;
            pend = 1'b0;
        end
    end

    function automatic logic [31:0] ta(input int i);
        return (i < tr_addr.size()) ? tr_addr[i] : 32'hBAD0_BAD0;
    endfunction
    function automatic logic [31:0] tw(input int i);
        return (i < tr_we.size()) ? 32'(tr_we[i]) : 32'hBAD0_BAD0;
    endfunction
    function automatic logic [31:0] twd(input int i);
        return (i < tr_wdata.size()) ? tr_wdata[i] : 32'hBAD0_BAD0;
    endfunction
    function automatic logic [31:0] tcd(input int i, input int j);
        return (j < tr_cyc.size()) ? 32'(tr_cyc[j] - tr_cyc[i]) : 32'hBAD0_BAD0;
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input int op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [31:0] v;
        v = imm;
        return {v[11:5], rs2[4:0], rs1[4:0], 3'b010, v[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], rs2[4:0], rs1[4:0], 3'b000, v[4:1], v[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], rd[4:0], 7'b1101111};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_007F;
    endtask

    task automatic clear_log();
        tr_addr.delete();
        tr_we.delete();
        tr_wdata.delete();
        tr_cyc.delete();
        unstable = 0;
        hold_cnt = 0;
    endtask

    task automatic start();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        clear_log();
        reset = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    localparam int OPI = 7'b0010011;

    initial begin
        int nw;

        // addi x1,x0,5 straight out of reset
        clear_mem();
        mem[0] = enc_i(5, 0, 0, 1, OPI);
        repeat (3) @(negedge clk);
        check_val("rst_req", 32'(mem_req), 32'h0);
        check_val("rst_pc", pc, 32'h0);
        check_val("rst_ill", 32'(illegal), 32'h0);
        clear_log();
        reset = 1'b0;
        run(30);
        check_val("addi_f0", ta(0), 32'h0);
        check_val("addi_f1", ta(1), 32'h4);
        check_val("addi_lat", tcd(0, 1), 32'd4);
        check_val("addi_x1", dut.rf_q[1], 32'd5);

        // lw x2,8(x0) with two wait states on the data read
        clear_mem();
        mem[0] = enc_i(8, 0, 2, 2, 7'b0000011);
        mem[2] = 32'hDEAD_BEEF;
        wait_addr = 32'h8;
        wait_n    = 2;
        hold_addr = 32'h8;
        start();
        run(30);
        check_val("lw_addr", ta(1), 32'h8);
        check_val("lw_we", tw(1), 32'h0);
        check_val("lw_done", tcd(0, 1), 32'd5);
        check_val("lw_next", ta(2), 32'h4);
        check_val("lw_lat", tcd(0, 2), 32'd7);
        check_val("lw_hold", 32'(hold_cnt), 32'd3);
        check_val("lw_stable", 32'(unstable), 32'd0);
        check_val("lw_x2", dut.rf_q[2], 32'hDEAD_BEEF);
        wait_addr = '1;
        wait_n    = 0;
        hold_addr = '1;

        // addi x1,x0,5 ; sw x1,12(x0)
        clear_mem();
        mem[0] = enc_i(5, 0, 0, 1, OPI);
        mem[1] = enc_s(12, 1, 0);
        start();
        run(30);
        check_val("sw_addr", ta(2), 32'hC);
        check_val("sw_we", tw(2), 32'h1);
        check_val("sw_wdata", twd(2), 32'h5);
        check_val("sw_next", ta(3), 32'h8);
        check_val("sw_lat", tcd(1, 3), 32'd4);
        check_val("sw_mem", mem[3], 32'h5);
        nw = 0;
        for (int i = 0; i < tr_we.size(); i++) if (tr_we[i]) nw++;
        check_val("sw_nwr", 32'(nw), 32'd1);

        // jal x0,12 to 0x10 ; beq x0,x0,-4 taken -> 0xC
        clear_mem();
        mem[0] = enc_i(5, 0, 0, 1, OPI);
        mem[1] = enc_j(12, 0);
        mem[4] = enc_b(-4, 0, 0);
        start();
        run(30);
        check_val("jal0_tgt", ta(2), 32'h10);
        check_val("jal0_lat", tcd(1, 2), 32'd3);
        check_val("beqt_tgt", ta(3), 32'hC);
        check_val("beqt_lat", tcd(2, 3), 32'd3);
        check_val("beqt_ill", 32'(illegal), 32'h1);

        // beq x1,x0,-4 with x1=5 not taken -> 0x14
        mem[4] = enc_b(-4, 0, 1);
        start();
        run(30);
        check_val("beqn_tgt", ta(3), 32'h14);
        check_val("beqn_lat", tcd(2, 3), 32'd3);

        // jal x1,16 at 0x20 ; add x0,x1,x1 ; sw x0,0x40 ; sw x1,0x44
        clear_mem();
        mem[0]  = enc_j(32, 0);
        mem[8]  = enc_j(16, 1);
        mem[12] = enc_r(0, 1, 1, 0, 0);
        mem[13] = enc_s(32'h40, 0, 0);
        mem[14] = enc_s(32'h44, 1, 0);
        start();
        run(40);
        check_val("jal_at20", ta(1), 32'h20);
        check_val("jal_tgt", ta(2), 32'h30);
        check_val("jal_lat", tcd(1, 2), 32'd3);
        check_val("add_next", ta(3), 32'h34);
        check_val("add_lat", tcd(2, 3), 32'd4);
        check_val("x0_addr", ta(4), 32'h40);
        check_val("x0_zero", twd(4), 32'h0);
        check_val("link_addr", ta(6), 32'h44);
        check_val("link_val", twd(6), 32'h24);
        check_val("link_end", ta(7), 32'h3C);

        // ALU mix with negative operands
        clear_mem();
        mem[0]  = enc_i(-3, 0, 0, 1, OPI);
        mem[1]  = enc_i(7, 0, 0, 2, OPI);
        mem[2]  = enc_r(32, 2, 1, 0, 3);
        mem[3]  = enc_r(0, 2, 1, 2, 4);
        mem[4]  = enc_r(0, 1, 2, 2, 5);
        mem[5]  = enc_r(0, 2, 1, 7, 6);
        mem[6]  = enc_r(0, 2, 1, 6, 7);
        mem[7]  = enc_i(-2, 1, 2, 8, OPI);
        mem[8]  = enc_i(-4, 2, 7, 9, OPI);
        mem[9]  = enc_i(32'h100, 2, 6, 10, OPI);
        mem[10] = enc_r(0, 2, 1, 0, 11);
        mem[11] = enc_i(-1, 2, 2, 12, OPI);
        start();
        run(70);
        check_val("sub", dut.rf_q[3], 32'hFFFF_FFF6);
        check_val("slt_t", dut.rf_q[4], 32'h1);
        check_val("slt_f", dut.rf_q[5], 32'h0);
        check_val("and", dut.rf_q[6], 32'h5);
        check_val("or", dut.rf_q[7], 32'hFFFF_FFFF);
        check_val("slti_t", dut.rf_q[8], 32'h1);
        check_val("andi", dut.rf_q[9], 32'h4);
        check_val("ori", dut.rf_q[10], 32'h107);
        check_val("add_wrap", dut.rf_q[11], 32'h4);
        check_val("slti_f", dut.rf_q[12], 32'h0);

        // unsupported opcode 0x7F
        clear_mem();
        start();
        run(40);
        check_val("trap_ill", 32'(illegal), 32'h1);
        check_val("trap_pc", pc, 32'h4);
        check_val("trap_req", 32'(mem_req), 32'h0);
        check_val("trap_ntr", 32'(tr_addr.size()), 32'd1);

        // reset while a fetch is stalled
        mem[0]    = enc_i(5, 0, 0, 1, OPI);
        wait_addr = 32'h0;
        wait_n    = 100;
        start();
        run(3);
        check_val("stall_req", 32'(mem_req), 32'h1);
        check_val("stall_addr", mem_addr, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("rstmid_req", 32'(mem_req), 32'h0);
        check_val("rstmid_ill", 32'(illegal), 32'h0);
        @(negedge clk);
        wait_n = 0;
        clear_log();
        reset = 1'b0;
        #2;
        check_val("rel_req", 32'(mem_req), 32'h1);
        check_val("rel_addr", mem_addr, 32'h0);
        check_val("rel_pc", pc, 32'h0);
        run(10);
        check_val("rel_f0", ta(0), 32'h0);
        check_val("rel_f1", ta(1), 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_mc_core.md
RISCV_MC_CORE -- requirements
Module: riscv_mc_core

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath, register and memory-bus width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 SHALL have ports: clk  in  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: mem_req  out  1  memory request valid.
REQ-006 SHALL have ports: mem_we  out  1  1 = write, 0 = read.
REQ-007 SHALL have ports: mem_addr  out  XLEN  byte address.
REQ-008 SHALL have ports: mem_wdata  out  XLEN  store data.
REQ-009 SHALL have ports: mem_rdata  in  XLEN  read data, valid in the cycle mem_ready=1.
REQ-010 SHALL have ports: mem_ready  in  1  completes the current request in this cycle.
REQ-011 SHALL have ports: illegal  out  1  sticky flag for an unsupported opcode.
REQ-012 SHALL have ports: pc  out  XLEN  current architectural PC.

Function
REQ-013 SHALL be a multicycle core with one unified memory port, supporting lw, sw, add, sub, and, or, slt, addi, andi, ori, slti, beq and jal.
REQ-014 SHALL use FSM states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL and TRAP.
REQ-015 SHALL handshake as follows: mem_req, mem_addr, mem_we and mem_wdata stay stable from assertion until a cycle with mem_ready=1; a transfer completes in that cycle; mem_ready may be high in the same cycle mem_req rises; mem_ready while mem_req=0 is ignored.
REQ-016 In FETCH, the core SHALL request a read at pc and stay in FETCH until mem_ready; on completion it latches IR<=mem_rdata, oldpc<=pc and pc<=pc+4, then moves to DECODE.
REQ-017 In DECODE, the core SHALL read rs1/rs2 into A/B and dispatch by opcode: lw/sw->MEMADR, R-type->EXECUTER, I-ALU->EXECUTEI, beq->BEQ, jal->JAL, any other->TRAP.
REQ-018 MEMADR SHALL compute ALUOut<=A+imm and go to MEMREAD (lw) or MEMWRITE (sw).
REQ-019 MEMREAD SHALL request a read at ALUOut, latch Data on mem_ready and go to MEMWB; MEMWB SHALL write rd<=Data and go to FETCH.
REQ-020 MEMWRITE SHALL request a write at ALUOut with mem_wdata=B and go to FETCH on mem_ready.
REQ-021 EXECUTER/EXECUTEI SHALL compute ALUOut from A op B or A op imm and go to ALUWB; ALUWB SHALL write rd<=ALUOut and go to FETCH.
REQ-022 BEQ SHALL set pc<=oldpc+immB when A==B, otherwise keep pc, then go to FETCH.
REQ-023 JAL SHALL set rd<=oldpc+4 and pc<=oldpc+immJ, then go to FETCH.
REQ-024 Latency with zero wait states SHALL be: lw 5, sw 4, R/I-ALU 4, jal 3, beq 3 cycles; each wait cycle adds exactly one cycle.
REQ-025 Arithmetic SHALL wrap modulo 2^XLEN; slt/slti SHALL compare signed; immediates SHALL be sign-extended to XLEN.
REQ-026 Writes to x0 SHALL be discarded, and x0 SHALL always read 0.
REQ-027 mem_addr SHALL be passed through unaligned, with no alignment check.
REQ-028 TRAP SHALL set illegal=1, hold mem_req=0 and keep pc unchanged; it is left only by reset.
REQ-029 mem_req SHALL be 0 in DECODE, MEMADR, EXECUTER, EXECUTEI, ALUWB, MEMWB, BEQ, JAL and TRAP.

Reset
REQ-030 On reset, state SHALL become FETCH, pc RESET_PC, illegal 0 and IR/oldpc/A/B/ALUOut/Data 0.
REQ-031 Register-file contents SHALL not be reset.
REQ-032 During reset, mem_req SHALL be 0; reset mid-transaction abandons the request, and the first request after reset is a fetch at RESET_PC.

Structure
REQ-033 Package riscv_mc_pkg SHALL hold the state enum, the opcode/funct constants and the 3-bit ALU control encoding (000 add, 001 sub, 010 and, 011 or, 101 slt).
REQ-034 The existing regfile, alu and extend blocks SHALL be reused; the FSM SHALL be the one natural sub-module, mc_ctrl.

Verification
REQ-035 Reset then mem_ready=1 always, memory holding addi x1,x0,5 at 0x0 -> fetch address 0x0, x1=5 after 4 cycles, next fetch at 0x4.
REQ-036 lw x2,8(x0) with word 0xDEADBEEF at 0x8 and 2 wait cycles on the data read -> mem_addr=0x8 held stable for 3 cycles, x2=0xDEADBEEF, total 7 cycles.
REQ-037 sw x1,12(x0) with x1=5 -> one request with mem_we=1, mem_addr=0xC, mem_wdata=5; next fetch at pc+4.
REQ-038 beq x0,x0,-4 at 0x10 -> next fetch at 0xC; bne-equivalent not-taken case (x1=5 vs x0) -> next fetch at 0x14.
REQ-039 jal x1,16 at 0x20 -> x1=0x24, next fetch at 0x30; add x0,x1,x1 -> x0 still reads 0.
REQ-040 Opcode 7'h7F -> illegal=1, mem_req stays 0 indefinitely; reset asserted mid-wait-state -> mem_req=0 next cycle, fetch at RESET_PC.
